// File: rtl/sr_drive_ctrl_if.sv
// Request and latch-drive bundle between a requester (master) and sr_drive_ctrl (slave).
interface sr_drive_ctrl_if;
    logic set_req;
    logic clr_req;
    logic s;
    logic r;
    logic gate;
    logic busy;
    logic q_shadow;
    logic err_conflict;
    logic err_overflow;

    modport master (
        output set_req, clr_req,
        input  s, r, gate, busy, q_shadow, err_conflict, err_overflow
    );

    modport slave (
        input  set_req, clr_req,
        output s, r, gate, busy, q_shadow, err_conflict, err_overflow
    );
endinterface

// File: rtl/sr_drive_ctrl.sv
// Debounced set/clear requests sequenced into glitch-free s/r/gate drive for an external SR latch,
// with a one-deep pending slot and conflict/overflow flags.
module sr_drive_ctrl #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned PULSE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sr_drive_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, PULSE = 2'd2, RELEASE = 2'd3} state_t;
    typedef enum logic {OP_CLR = 1'b0, OP_SET = 1'b1} op_t;

    localparam logic [7:0] DEB_LAST   = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

    // Bit 0 carries the set request, bit 1 the clear request.
    logic [1:0] raw, meta, sync, deb, ev;
    logic [7:0] cnt [2];

    assign raw = {bus.clr_req, bus.set_req};

    // NOTE: sequential state uses <= so every flop samples pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            ev  <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                ev[i] <= 1'b0;
                if (sync[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    deb[i] <= sync[i];
                    cnt[i] <= '0;
                    ev[i]  <= sync[i];  // only a rising debounced level is a command
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    state_t     state, state_nxt;
    op_t        op, op_nxt, pend_op, pend_op_nxt, new_op;
    logic       pend_valid, pend_valid_nxt, new_ev;
    logic [7:0] pcnt, pcnt_nxt;
    logic       q_q, q_nxt, ovf_nxt;
    logic       s_q, r_q, gate_q, busy_q, conf_q, ovf_q;
    logic       s_nxt, r_nxt, gate_nxt, busy_nxt;

    // Coincident set and clear cancel each other; only a lone event is a command.
    assign new_ev = ev[0] ^ ev[1];
    assign new_op = ev[0] ? OP_SET : OP_CLR;

    // NOTE: every output of this block is given a default first, so no path infers a latch.
    always_comb begin
        state_nxt      = state;
        op_nxt         = op;
        pcnt_nxt       = pcnt;
        pend_valid_nxt = pend_valid;
        pend_op_nxt    = pend_op;
        q_nxt          = q_q;
        ovf_nxt        = 1'b0;

        case (state)
            IDLE: begin
                if (pend_valid) begin
                    op_nxt         = pend_op;
                    state_nxt      = SETUP;
                    pend_valid_nxt = new_ev;
                    if (new_ev) pend_op_nxt = new_op;
                end else if (new_ev) begin
                    op_nxt    = new_op;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = PULSE;
                pcnt_nxt  = '0;
            end
            PULSE: begin
                if (pcnt == PULSE_LAST) state_nxt = RELEASE;
                else                    pcnt_nxt  = pcnt + 8'd1;
            end
            RELEASE: begin
                state_nxt = IDLE;
                q_nxt     = (op == OP_SET);
            end
            default: state_nxt = IDLE;
        endcase

        if (state != IDLE && new_ev) begin
            if (!pend_valid) begin
                pend_valid_nxt = 1'b1;
                pend_op_nxt    = new_op;
            end else begin
                ovf_nxt = 1'b1;
            end
        end

        // Outputs decode from the next state so they can be registered without added latency.
        s_nxt    = 1'b1;
        r_nxt    = 1'b1;
        if (state_nxt != IDLE) begin
            s_nxt = (op_nxt == OP_CLR);
            r_nxt = (op_nxt == OP_SET);
        end
        gate_nxt = (state_nxt == PULSE);
        busy_nxt = (state_nxt != IDLE);
    end

    // NOTE: the pending slot and opcode are reset too, so a reset mid-command discards it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= OP_CLR;
            pend_valid <= 1'b0;
            pend_op    <= OP_CLR;
            pcnt       <= '0;
            q_q        <= 1'b0;
            s_q        <= 1'b1;
            r_q        <= 1'b1;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
            conf_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            op         <= op_nxt;
            pend_valid <= pend_valid_nxt;
            pend_op    <= pend_op_nxt;
            pcnt       <= pcnt_nxt;
            q_q        <= q_nxt;
            s_q        <= s_nxt;
            r_q        <= r_nxt;
            gate_q     <= gate_nxt;
            busy_q     <= busy_nxt;
            conf_q     <= ev[0] & ev[1];
            ovf_q      <= ovf_nxt;
        end
    end

    assign bus.s            = s_q;
    assign bus.r            = r_q;
    assign bus.gate         = gate_q;
    assign bus.busy         = busy_q;
    assign bus.q_shadow     = q_q;
    assign bus.err_conflict = conf_q;
    assign bus.err_overflow = ovf_q;
endmodule
